regfile_wb_arbiter: RTL

Writeback arbiter and scheduler for the 32 x 64-bit register bank's single write port (`register3` / `datain` / `regwrite`). Several producers compete for that one port; this block arbitrates them round-robin with a valid/ready handshake, registers the winner into a one-entry writeback stage, and drives the bank's write port from it. It also keeps a per-register pending scoreboard so hazard logic can tell which registers still have a write in flight.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/regfile_wb_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and types for the register bank writeback path.
package regfile_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef struct packed {
    reg_idx_t  addr;
    reg_data_t data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted index.
// The pointer moves only when the caller reports a completed transfer.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int LAST_W = (N > 1) ? $clog2(N) : 1;

  logic [LAST_W-1:0] last_q, last_d;
  logic [LAST_W-1:0] sel;

  // NOTE: every output and temporary gets a default before the search loop,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    sel   = last_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        sel        = LAST_W'(idx);
      end
    end
  end

  assign last_d = advance ? sel : last_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= LAST_W'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register bank's single write port, with a pending
// scoreboard. Define WB_ZERO_DROP_EN to silently drop writes to ZERO_REG.
module regfile_wb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int ZERO_REG = 31
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wb_stall,
  output logic                      wb_regwrite,
  output logic [ADDR_W-1:0]         wb_register3,
  output logic [DATA_W-1:0]         wb_datain,
  output logic [(1<<ADDR_W)-1:0]    pending
);

  localparam int NUM_REGS = 1 << ADDR_W;
`ifdef WB_ZERO_DROP_EN
  localparam logic ZERO_DROP = 1'b1;
`else
  localparam logic ZERO_DROP = 1'b0;
`endif

  logic [NUM_REQ-1:0]  grant;
  logic                xfer, zero_hit, load, accept_ok;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  logic                stage_valid_q, stage_valid_d;
  logic [ADDR_W-1:0]   stage_addr_q, stage_addr_d;
  logic [DATA_W-1:0]   stage_data_q, stage_data_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (xfer),
    .grant   (grant)
  );

  // The stage can take a new entry when empty or when it is draining this cycle.
  assign accept_ok = !stage_valid_q || !wb_stall;
  assign req_ready = reset ? '0 : (grant & {NUM_REQ{accept_ok}});
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign zero_hit = (sel_addr == ADDR_W'(ZERO_REG));
  assign load     = xfer && !(zero_hit && ZERO_DROP);

  assign wb_regwrite  = stage_valid_q && !wb_stall;
  assign wb_register3 = stage_addr_q;
  assign wb_datain    = stage_data_q;
  assign pending      = pending_q;

  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_addr_d  = stage_addr_q;
    stage_data_d  = stage_data_q;
    if (load) begin
      stage_valid_d = 1'b1;
      stage_addr_d  = sel_addr;
      stage_data_d  = sel_data;
    end else if (!wb_stall) begin
      stage_valid_d = 1'b0;
    end
  end

  // Clear for the committing entry first so a same-edge set wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_regwrite) pending_d[stage_addr_q] = 1'b0;
    if (load)        pending_d[sel_addr]     = 1'b1;
  end

  // NOTE: the stage data is reset as well, because the bank-facing outputs
  // must read zero after reset rather than stale contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid_q <= 1'b0;
      stage_addr_q  <= '0;
      stage_data_q  <= '0;
      pending_q     <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_addr_q  <= stage_addr_d;
      stage_data_q  <= stage_data_d;
      pending_q     <= pending_d;
    end
  end

endmodule
